// File: rtl/dcache_assoc_param.sv
// Parametrised N-way set-associative write-back/write-allocate data cache with
// true-LRU replacement, halt-time flush and hit/miss counter writeback.
module dcache_assoc_param #(
    parameter int          SETS       = 8,
    parameter int          WAYS       = 2,
    parameter int          BLKWORDS   = 2,
    parameter logic [31:0] COUNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int OFF_BITS = $clog2(BLKWORDS);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int TAG_W    = 30 - OFF_BITS - IDX_BITS;
    localparam int OW       = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int AW       = (WAY_BITS > 0) ? WAY_BITS : 1;
    localparam int LINES    = SETS * WAYS;
    localparam int PW       = $clog2(LINES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        LD    = 3'd2,
        FSCAN = 3'd3,
        FWB   = 3'd4,
        WCNT  = 3'd5,
        HALT  = 3'd6
    } state_t;

    state_t              state_r, state_n;
    logic                valid_r [SETS][WAYS];
    logic                dirty_r [SETS][WAYS];
    logic [TAG_W-1:0]    tag_r   [SETS][WAYS];
    logic [AW-1:0]       age_r   [SETS][WAYS];
    logic [31:0]         data_r  [SETS][WAYS][BLKWORDS];
    logic [OW-1:0]       ctr_r;
    logic [AW-1:0]       victim_r;
    logic [PW-1:0]       ptr_r;
    logic                sel_r;
    logic [31:0]         hitcnt_r;
    logic [31:0]         misscnt_r;

    logic [TAG_W-1:0]    req_tag_s;
    logic [IDX_BITS-1:0] req_idx_s;
    logic [OW-1:0]       req_off_s;
    logic                req_s, hit_s, inv_found_s, xfer_s, ctr_last_s, ptr_last_s;
    logic [AW-1:0]       hit_way_s, victim_s, cur_age_s, fway_s;
    logic [IDX_BITS-1:0] fset_s;

    // Rebuild a byte address from line coordinates.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t,
                                              input logic [IDX_BITS-1:0] i,
                                              input logic [OW-1:0] o);
        return (32'(t) << (2 + OFF_BITS + IDX_BITS)) | (32'(i) << (2 + OFF_BITS)) |
               ((32'(o) & 32'(BLKWORDS - 1)) << 2);
    endfunction

    assign req_tag_s  = TAG_W'(dmemaddr >> (2 + OFF_BITS + IDX_BITS));
    assign req_idx_s  = IDX_BITS'(dmemaddr >> (2 + OFF_BITS));
    assign req_off_s  = OW'((dmemaddr >> 2) & 32'(BLKWORDS - 1));
    assign req_s      = dmemREN | dmemWEN;
    assign xfer_s     = ~dwait;
    assign ctr_last_s = (ctr_r == OW'(BLKWORDS - 1));
    assign ptr_last_s = (ptr_r == PW'(LINES - 1));
    assign fset_s     = IDX_BITS'(ptr_r / WAYS);
    assign fway_s     = AW'(ptr_r % WAYS);
    assign cur_age_s  = age_r[req_idx_s][hit_way_s];

    // Tag lookup and victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        victim_s    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[req_idx_s][w] && (tag_r[req_idx_s][w] == req_tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = AW'(w);
            end else begin
                hit_s = hit_s;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_r[req_idx_s][w]) begin
                inv_found_s = 1'b1;
                victim_s    = AW'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        if (!inv_found_s) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_r[req_idx_s][w] == AW'(WAYS - 1)) victim_s = AW'(w);
                else victim_s = victim_s;
            end
        end else begin
            victim_s = victim_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_n  = state_r;
        dhit     = 1'b0;
        dmemload = 32'h0000_0000;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'h0000_0000;
        dstore   = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (req_s && hit_s) begin
                    dhit     = 1'b1;
                    dmemload = data_r[req_idx_s][hit_way_s][req_off_s];
                end else if (req_s) begin
                    state_n = dirty_r[req_idx_s][victim_s] ? WB : LD;
                end else if (halt) begin
                    state_n = FSCAN;
                end else begin
                    state_n = IDLE;
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = line_addr(tag_r[req_idx_s][victim_r], req_idx_s, ctr_r);
                dstore = data_r[req_idx_s][victim_r][ctr_r];
                if (xfer_s && ctr_last_s) state_n = LD;
                else state_n = WB;
            end
            LD: begin
                dREN  = 1'b1;
                daddr = line_addr(req_tag_s, req_idx_s, ctr_r);
                if (xfer_s && ctr_last_s) state_n = IDLE;
                else state_n = LD;
            end
            FSCAN: begin
                if (valid_r[fset_s][fway_s] && dirty_r[fset_s][fway_s]) state_n = FWB;
                else if (ptr_last_s) state_n = WCNT;
                else state_n = FSCAN;
            end
            FWB: begin
                dWEN   = 1'b1;
                daddr  = line_addr(tag_r[fset_s][fway_s], fset_s, ctr_r);
                dstore = data_r[fset_s][fway_s][ctr_r];
                if (xfer_s && ctr_last_s) state_n = ptr_last_s ? WCNT : FSCAN;
                else state_n = FWB;
            end
            WCNT: begin
                dWEN   = 1'b1;
                daddr  = sel_r ? (COUNT_ADDR + 32'd4) : COUNT_ADDR;
                dstore = sel_r ? misscnt_r : hitcnt_r;
                if (xfer_s && sel_r) state_n = HALT;
                else state_n = WCNT;
            end
            HALT: begin
                flushed = 1'b1;
                state_n = HALT;
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state, line metadata, LRU ages and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            ctr_r     <= '0;
            victim_r  <= '0;
            ptr_r     <= '0;
            sel_r     <= 1'b0;
            hitcnt_r  <= 32'h0000_0000;
            misscnt_r <= 32'h0000_0000;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w] <= 1'b0;
                    dirty_r[s][w] <= 1'b0;
                    tag_r[s][w]   <= '0;
                    age_r[s][w]   <= AW'(w);
                end
            end
        end else begin
            state_r <= state_n;
            case (state_r)
                IDLE: begin
                    if (req_s && hit_s) begin
                        hitcnt_r <= hitcnt_r + 32'd1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (AW'(w) == hit_way_s) age_r[req_idx_s][w] <= '0;
                            else if (age_r[req_idx_s][w] < cur_age_s)
                                age_r[req_idx_s][w] <= age_r[req_idx_s][w] + AW'(1);
                        end
                        if (dmemWEN) dirty_r[req_idx_s][hit_way_s] <= 1'b1;
                    end else if (req_s) begin
                        misscnt_r <= misscnt_r + 32'd1;
                        victim_r  <= victim_s;
                        ctr_r     <= '0;
                    end else if (halt) begin
                        ptr_r <= '0;
                        ctr_r <= '0;
                        sel_r <= 1'b0;
                    end
                end
                WB: begin
                    if (xfer_s) begin
                        ctr_r <= ctr_last_s ? '0 : ctr_r + OW'(1);
                        if (ctr_last_s) dirty_r[req_idx_s][victim_r] <= 1'b0;
                    end
                end
                LD: begin
                    if (xfer_s) begin
                        ctr_r <= ctr_last_s ? '0 : ctr_r + OW'(1);
                        // The line stays invalid until its final word has landed.
                        valid_r[req_idx_s][victim_r] <= ctr_last_s;
                        if (ctr_last_s) begin
                            tag_r[req_idx_s][victim_r]   <= req_tag_s;
                            dirty_r[req_idx_s][victim_r] <= 1'b0;
                        end
                    end
                end
                FSCAN: begin
                    if (valid_r[fset_s][fway_s] && dirty_r[fset_s][fway_s]) ctr_r <= '0;
                    else if (!ptr_last_s) ptr_r <= ptr_r + PW'(1);
                end
                FWB: begin
                    if (xfer_s) begin
                        ctr_r <= ctr_last_s ? '0 : ctr_r + OW'(1);
                        if (ctr_last_s) begin
                            dirty_r[fset_s][fway_s] <= 1'b0;
                            if (!ptr_last_s) ptr_r <= ptr_r + PW'(1);
                        end
                    end
                end
                WCNT: begin
                    if (xfer_s) sel_r <= 1'b1;
                end
                default: sel_r <= sel_r;
            endcase
        end
    end

    // Line data: write hits and fill words; contents are qualified by valid.
    always_ff @(posedge CLK) begin
        if ((state_r == IDLE) && req_s && hit_s && dmemWEN)
            data_r[req_idx_s][hit_way_s][req_off_s] <= dmemstore;
        else if ((state_r == LD) && xfer_s)
            data_r[req_idx_s][victim_r][ctr_r] <= dload;
    end
endmodule

// File: tb/tb_dcache_assoc_param.sv
// Randomised bench for dcache_assoc_param: a memory responder plus a per-set
// LRU tag list model predicts read data, memory traffic and flush results.
module tb_dcache_assoc_param;
    localparam int          SETS     = 4;
    localparam int          WAYS     = 4;
    localparam int          BLKWORDS = 2;
    localparam logic [31:0] CADDR    = 32'h0000_3100;

    logic        CLK, nRST, dmemREN, dmemWEN, halt, dhit, flushed, dREN, dWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

    dcache_assoc_param #(.SETS(SETS), .WAYS(WAYS), .BLKWORDS(BLKWORDS), .COUNT_ADDR(CADDR)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed { logic [31:0] tag; logic dirty; } line_t;

    int          checks, errors, wait_mode, m_hits, m_misses, last_ncyc;
    logic [31:0] last_rd;
    logic [31:0] mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] rd_log[$], wr_log[$], exp_rd_q[$], exp_wr_q[$];
    line_t       sets_q [SETS][$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return mem_rd(a);
    endfunction
    // tag | set | word | byte, for 4 sets of 2-word blocks
    function automatic logic [31:0] blk(input logic [31:0] t, input int s, input int w);
        return (t << 5) | (32'(s) << 3) | (32'(w) << 2);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) sets_q[s].delete();
        m_hits = 0;
        m_misses = 0;
        ref_mem.delete();
    endtask

    // Each set is an MRU-first list of resident tags; a full list evicts its tail.
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                output bit miss);
        int s, found;
        logic [31:0] t;
        line_t l, v;
        s = int'((a >> 3) & 32'd3);
        t = a >> 5;
        found = -1;
        miss = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        for (int i = 0; i < sets_q[s].size(); i++) if (sets_q[s][i].tag == t) found = i;
        if (found >= 0) begin
            l = sets_q[s][found];
            sets_q[s].delete(found);
        end else begin
            miss = 1'b1;
            m_misses++;
            if (sets_q[s].size() == WAYS) begin
                v = sets_q[s].pop_back();
                if (v.dirty) for (int w = 0; w < BLKWORDS; w++) exp_wr_q.push_back(blk(v.tag, s, w));
            end
            for (int w = 0; w < BLKWORDS; w++) exp_rd_q.push_back(blk(t, s, w));
            l.tag = t;
            l.dirty = 1'b0;
        end
        if (wr) begin
            l.dirty = 1'b1;
            ref_mem[a] = wd;
        end
        sets_q[s].push_front(l);
        m_hits++;
    endtask

    // One clock: memory responds before the edge, outputs sampled mid-cycle.
    task automatic tick(output bit h, output logic [31:0] ld);
        @(negedge CLK);
        dwait = (wait_mode == 1) ? 1'b1 : (wait_mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
        #1;
        dload = dREN ? mem_rd(daddr) : 32'h0000_0000;
        #1;
        h = dhit;
        ld = dmemload;
        if (!dwait && dWEN) begin
            mem[daddr] = dstore;
            wr_log.push_back(daddr);
        end
        if (!dwait && dREN) rd_log.push_back(daddr);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             output bit timeout);
        bit h;
        logic [31:0] ld;
        rd_log.delete();
        wr_log.delete();
        dmemREN = ~wr;
        dmemWEN = wr;
        dmemaddr = a;
        dmemstore = wd;
        h = 1'b0;
        last_ncyc = 0;
        while (!h && last_ncyc < 500) begin
            tick(h, ld);
            last_ncyc++;
        end
        last_rd = ld;
        timeout = ~h;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic checked_access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
        bit miss, to, ok;
        logic [31:0] exp_data;
        exp_data = ref_rd(a);
        model_access(wr, a, wd, miss);
        do_access(wr, a, wd, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL access_timeout addr=%h got no dhit expected dhit", a);
        end
        if (!wr) begin
            checks++;
            if (last_rd !== exp_data) begin
                errors++;
                $display("FAIL read_data addr=%h got=%h expected=%h", a, last_rd, exp_data);
            end
        end
        ok = (rd_log.size() == exp_rd_q.size());
        for (int i = 0; ok && i < rd_log.size(); i++) if (rd_log[i] !== exp_rd_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fill_traffic addr=%h got %0d reads expected %0d reads (first exp %h)",
                     a, rd_log.size(), exp_rd_q.size(), blk(a >> 5, int'((a >> 3) & 32'd3), 0));
        end
        ok = (wr_log.size() == exp_wr_q.size());
        for (int i = 0; ok && i < wr_log.size(); i++) if (wr_log[i] !== exp_wr_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL writeback_traffic addr=%h got %0d writes expected %0d writes",
                     a, wr_log.size(), exp_wr_q.size());
        end
        if (!miss) begin
            checks++;
            if (last_ncyc != 1) begin
                errors++;
                $display("FAIL hit_latency addr=%h got=%0d cycles expected=1", a, last_ncyc);
            end
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        halt = 1'b0;
        dwait = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #1;
        checks++;
        if ({dhit, dmemload, flushed, dREN, dWEN, daddr, dstore} !== 100'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {dhit, dmemload, flushed, dREN, dWEN, daddr, dstore});
        end
        do_reset();
        checks++;
        if ({dhit, dmemload, flushed, dREN, dWEN, daddr, dstore} !== 100'd0) begin
            errors++;
            $display("FAIL idle_outputs got=%h expected=0",
                     {dhit, dmemload, flushed, dREN, dWEN, daddr, dstore});
        end
    endtask

    task automatic test_cold_read();
        wait_mode = 2;
        checked_access(1'b0, 32'h0000_0100, 32'h0);
        checks++;
        if (last_ncyc != BLKWORDS + 2) begin
            errors++;
            $display("FAIL clean_miss_latency got=%0d expected=%0d", last_ncyc, BLKWORDS + 2);
        end
    endtask

    task automatic test_write_hit();
        checked_access(1'b1, 32'h0000_0104, 32'h0000_DEAD);
        checked_access(1'b0, 32'h0000_0104, 32'h0);
        checks++;
        if (last_rd !== 32'h0000_DEAD) begin
            errors++;
            $display("FAIL reread_dead got=%h expected=0000dead", last_rd);
        end
    endtask

    task automatic test_lru4();
        wait_mode = 2;
        for (int t = 1; t <= 4; t++) checked_access(1'b1, blk(32'(t), 1, 0), 32'(t) * 32'h1111);
        checked_access(1'b0, blk(32'd2, 1, 0), 32'h0);
        checked_access(1'b0, blk(32'd5, 1, 0), 32'h0);
        checks++;
        if (wr_log.size() < 1 || wr_log[0] !== blk(32'd1, 1, 0)) begin
            errors++;
            $display("FAIL lru_evict_t0 got %0d writes expected first write %h", wr_log.size(), blk(32'd1, 1, 0));
        end
        checks++;
        if (last_ncyc != 2 * BLKWORDS + 2) begin
            errors++;
            $display("FAIL dirty_miss_latency got=%0d expected=%0d", last_ncyc, 2 * BLKWORDS + 2);
        end
        checked_access(1'b0, blk(32'd6, 1, 0), 32'h0);
        checks++;
        if (wr_log.size() < 1 || wr_log[0] !== blk(32'd3, 1, 0)) begin
            errors++;
            $display("FAIL lru_evict_t2 got %0d writes expected first write %h", wr_log.size(), blk(32'd3, 1, 0));
        end
    endtask

    task automatic test_random();
        wait_mode = 0;
        for (int i = 0; i < 300; i++)
            checked_access(bit'($urandom_range(0, 1)),
                           blk(32'($urandom_range(1, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1))),
                           $urandom);
    endtask

    task automatic test_reset_mid_ld();
        bit h;
        logic [31:0] ld;
        do_reset();
        wait_mode = 1;
        dmemREN = 1'b1;
        dmemaddr = blk(32'd14, 2, 0);
        repeat (3) tick(h, ld);
        checks++;
        if (dREN !== 1'b1 || daddr !== blk(32'd14, 2, 0)) begin
            errors++;
            $display("FAIL ld_busy got dREN=%b daddr=%h expected dREN=1 daddr=%h", dREN, daddr, blk(32'd14, 2, 0));
        end
        nRST = 1'b0;
        #1;
        checks++;
        if ({dhit, dmemload, flushed, dREN, dWEN, daddr, dstore} !== 100'd0) begin
            errors++;
            $display("FAIL reset_mid_ld got=%h expected=0", {dhit, dmemload, flushed, dREN, dWEN, daddr, dstore});
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        dmemREN = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();
        wait_mode = 0;
        checked_access(1'b0, blk(32'd14, 2, 0), 32'h0);
    endtask

    task automatic test_halt();
        bit h, ok;
        logic [31:0] ld;
        int n, nwr;
        do_reset();
        wait_mode = 0;
        checked_access(1'b1, 32'h0000_0040, 32'hA0A0_0001);
        checked_access(1'b1, 32'h0000_0048, 32'hA0A0_0002);
        checked_access(1'b1, 32'h0000_0054, 32'hA0A0_0003);
        checked_access(1'b0, 32'h0000_0040, 32'h0);
        checked_access(1'b0, 32'h0000_0054, 32'h0);
        wr_log.delete();
        rd_log.delete();
        halt = 1'b1;
        n = 0;
        while (flushed !== 1'b1 && n < 2000) begin
            tick(h, ld);
            n++;
        end
        checks++;
        if (flushed !== 1'b1) begin
            errors++;
            $display("FAIL flush_timeout got flushed=%b expected 1", flushed);
        end
        nwr = wr_log.size();
        checks++;
        if (nwr != 3 * BLKWORDS + 2) begin
            errors++;
            $display("FAIL flush_write_count got=%0d expected=%0d", nwr, 3 * BLKWORDS + 2);
        end
        checks++;
        if (nwr < 2 || wr_log[nwr-2] !== CADDR || wr_log[nwr-1] !== CADDR + 32'd4) begin
            errors++;
            $display("FAIL counter_addr_order got %0d writes expected counters last at %h,%h", nwr, CADDR, CADDR + 32'd4);
        end
        checks++;
        if (mem_rd(CADDR) !== 32'(m_hits)) begin
            errors++;
            $display("FAIL hit_counter got=%0d expected=%0d", mem_rd(CADDR), m_hits);
        end
        checks++;
        if (mem_rd(CADDR + 32'd4) !== 32'(m_misses)) begin
            errors++;
            $display("FAIL miss_counter got=%0d expected=%0d", mem_rd(CADDR + 32'd4), m_misses);
        end
        ok = 1'b1;
        foreach (ref_mem[a]) if (mem_rd(a) !== ref_mem[a]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flushed_data got memory differing from written values expected all equal");
        end
        rd_log.delete();
        wr_log.delete();
        dmemREN = 1'b1;
        dmemaddr = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            tick(h, ld);
            checks++;
            if (flushed !== 1'b1 || h !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold got flushed=%b dhit=%b expected flushed=1 dhit=0", flushed, h);
            end
        end
        checks++;
        if (rd_log.size() != 0 || wr_log.size() != 0) begin
            errors++;
            $display("FAIL halt_traffic got %0d transfers expected 0", rd_log.size() + wr_log.size());
        end
        dmemREN = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wait_mode = 0;
        nRST = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        dmemaddr = 32'h0;
        dmemstore = 32'h0;
        halt = 1'b0;
        dwait = 1'b1;
        dload = 32'h0;
        model_reset();
        test_reset();
        test_cold_read();
        test_write_hit();
        test_lru4();
        test_random();
        test_reset_mid_ld();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
